// File: rtl/stopwatch_bcd_core.sv
// Stopwatch core: counts SS.hh in BCD from a prescaled tick, with debounced
// start/stop and lap/clear keys.
// Ports:
//   clk_50       - sole clock, rising edge
//   reset        - synchronous active-high reset
//   btn_start_n  - raw start/stop key, low = pressed
//   btn_lap_n    - raw lap/clear key, low = pressed
//   digits       - {tens_s, s, tenths, hundredths} BCD, registered
//   running      - high while in RUN
//   lap_active   - high while digits shows a frozen lap snapshot
//   overflow     - sticky, set on 59.99 -> 00.00
//   update       - one-cycle strobe in the cycle after digits changed
module stopwatch_bcd_core #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned TICK_HZ         = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        btn_start_n,
  input  logic        btn_lap_n,
  output logic [15:0] digits,
  output logic        running,
  output logic        lap_active,
  output logic        overflow,
  output logic        update
);

  localparam int unsigned PRESCALE = CLK_HZ / TICK_HZ;
  localparam int unsigned PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;

  // Index 0 = start key, index 1 = lap key
  logic [1:0]            s1_q, s1_d, s2_q, s2_d;
  logic [1:0]            last_q, last_d, acc_q, acc_d, armed_q, armed_d;
  logic [1:0][DB_W-1:0]  cnt_q, cnt_d;
  logic [1:0]            press_c;

  state_t          state_q, state_d;
  logic            hold_q, hold_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [15:0]     count_q, count_d, snap_q, snap_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     digits_q, digits_d;
  logic            running_q, running_d, lap_q, lap_d, update_q, update_d;

  logic            start_ev_c, lap_ev_c, tick_c, wrap_c;
  logic [15:0]     inc_c;

  // BCD increment with per-digit wrap; bit 16 flags the 59.99 -> 00.00 wrap
  function automatic logic [16:0] bcd_inc(input logic [15:0] c);
    logic [15:0] n;
    logic        w;
    n = c;
    w = 1'b0;
    if (c[3:0] < 4'd9) n[3:0] = c[3:0] + 4'd1;
    else begin
      n[3:0] = 4'd0;
      if (c[7:4] < 4'd9) n[7:4] = c[7:4] + 4'd1;
      else begin
        n[7:4] = 4'd0;
        if (c[11:8] < 4'd9) n[11:8] = c[11:8] + 4'd1;
        else begin
          n[11:8] = 4'd0;
          if (c[15:12] < 4'd5) n[15:12] = c[15:12] + 4'd1;
          else begin
            n[15:12] = 4'd0;
            w        = 1'b1;
          end
        end
      end
    end
    return {w, n};
  endfunction

  // Synchronizers and debouncers. cnt counts consecutive identical samples;
  // a key is armed only after a full stable released window, so a key held
  // through reset produces no press until it is released and pressed again.
  always_comb begin
    s1_d    = {btn_lap_n, btn_start_n};
    s2_d    = s1_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    armed_d = armed_q;
    press_c = 2'b00;
    for (int i = 0; i < 2; i++) begin
      last_d[i] = s2_q[i];
      if (s2_q[i] != last_q[i])  cnt_d[i] = DB_W'(1);
      else if (cnt_q[i] != DB_MAX) cnt_d[i] = cnt_q[i] + DB_W'(1);
      if (cnt_d[i] == DB_MAX) begin
        acc_d[i] = last_d[i];
        if (last_d[i]) armed_d[i] = 1'b1;
      end
      press_c[i] = armed_q[i] & acc_q[i] & ~acc_d[i];
    end
  end

  // FSM, prescaler, BCD counter and lap snapshot
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    ps_d       = ps_q;
    count_d    = count_q;
    snap_d     = snap_q;
    ovf_d      = ovf_q;
    tick_c     = 1'b0;
    start_ev_c = press_c[0];
    lap_ev_c   = press_c[1] & ~press_c[0];
    {wrap_c, inc_c} = bcd_inc(count_q);

    if (state_q == ST_RUN) begin
      if (ps_q == PS_LAST) begin
        ps_d   = '0;
        tick_c = 1'b1;
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end

    if (tick_c) begin
      count_d = inc_c;
      if (wrap_c) ovf_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_ev_c) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_ev_c) state_d = ST_PAUSE;
        else if (lap_ev_c) begin
          hold_d = ~hold_q;
          if (!hold_q) snap_d = count_q;
        end
      end
      ST_PAUSE: begin
        if (start_ev_c) state_d = ST_RUN;
        else if (lap_ev_c) begin
          state_d = ST_IDLE;
          count_d = '0;
          snap_d  = '0;
          ps_d    = '0;
          ovf_d   = 1'b0;
          hold_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    digits_d  = hold_q ? snap_q : count_q;
    update_d  = (digits_d != digits_q);
    running_d = (state_q == ST_RUN);
    lap_d     = hold_q;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      s1_q      <= 2'b11;
      s2_q      <= 2'b11;
      last_q    <= 2'b11;
      acc_q     <= 2'b11;
      armed_q   <= 2'b00;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      hold_q    <= 1'b0;
      ps_q      <= '0;
      count_q   <= '0;
      snap_q    <= '0;
      ovf_q     <= 1'b0;
      digits_q  <= '0;
      running_q <= 1'b0;
      lap_q     <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      last_q    <= last_d;
      acc_q     <= acc_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      ps_q      <= ps_d;
      count_q   <= count_d;
      snap_q    <= snap_d;
      ovf_q     <= ovf_d;
      digits_q  <= digits_d;
      running_q <= running_d;
      lap_q     <= lap_d;
      update_q  <= update_d;
    end
  end

  assign digits     = digits_q;
  assign running    = running_q;
  assign lap_active = lap_q;
  assign overflow   = ovf_q;
  assign update     = update_q;

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Directed bench for stopwatch_bcd_core at CLK_HZ=100, TICK_HZ=10,
// DEBOUNCE_CYCLES=4 (one tick every 10 clocks). Inputs change and outputs
// are sampled on the falling edge. Timing notes: a key driven low after
// edge P0 is accepted (event) at edge P6; ticks follow at P6+10k and digits
// shows tick k from edge P7+10k.
module tb_stopwatch_bcd_core;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic        btn_start_n;
  logic        btn_lap_n;
  logic [15:0] digits;
  logic        running;
  logic        lap_active;
  logic        overflow;
  logic        update;

  int checks = 0;
  int errors = 0;
  int upd_total = 0;
  int upd_mark;

  stopwatch_bcd_core #(
    .CLK_HZ(100),
    .TICK_HZ(10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_50(clk_50),
    .reset(reset),
    .btn_start_n(btn_start_n),
    .btn_lap_n(btn_lap_n),
    .digits(digits),
    .running(running),
    .lap_active(lap_active),
    .overflow(overflow),
    .update(update)
  );

  always #5 clk_50 = ~clk_50;

  // Counts update pulses; at a posedge the value seen is the one held since the last edge
  always @(posedge clk_50) if (update === 1'b1) upd_total = upd_total + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  // Drive selected keys low for 8 clocks, then release; returns after P8
  task automatic push(input logic st, input logic lp);
    if (st) btn_start_n = 1'b0;
    if (lp) btn_lap_n = 1'b0;
    wait_clk(8);
    btn_start_n = 1'b1;
    btn_lap_n   = 1'b1;
  endtask

  task automatic do_reset();
    btn_start_n = 1'b1;
    btn_lap_n   = 1'b1;
    reset       = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(8);
  endtask

  initial begin
    btn_start_n = 1'b1;
    btn_lap_n   = 1'b1;
    reset       = 1'b1;
    wait_clk(3);
    check("rst_digits",  32'(digits), 32'h0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_lap",     32'(lap_active), 32'd0);
    check("rst_ovf",     32'(overflow), 32'd0);
    check("rst_update",  32'(update), 32'd0);
    reset = 1'b0;
    wait_clk(8);

    // Lap in IDLE is ignored
    push(1'b0, 1'b1);
    wait_clk(10);
    check("idle_lap_run", 32'(running), 32'd0);
    check("idle_lap_act", 32'(lap_active), 32'd0);

    // Run 100 clocks from start: ten ticks, ten update strobes
    do_reset();
    push(1'b1, 1'b0);
    upd_mark = upd_total;
    wait_clk(99);
    check("run_digits",  32'(digits), 32'h0010);
    check("run_running", 32'(running), 32'd1);
    wait_clk(1);
    check("run_updates", 32'(upd_total - upd_mark), 32'd10);

    // Bouncing start key: short lows are rejected, a stable low gives one event
    do_reset();
    btn_start_n = 1'b0; wait_clk(2);
    btn_start_n = 1'b1; wait_clk(2);
    btn_start_n = 1'b0; wait_clk(3);
    btn_start_n = 1'b1; wait_clk(1);
    btn_start_n = 1'b0; wait_clk(1);
    btn_start_n = 1'b1; wait_clk(10);
    check("bounce_none", 32'(running), 32'd0);
    push(1'b1, 1'b0);
    wait_clk(4);
    check("bounce_one", 32'(running), 32'd1);

    // Key held low through reset gives no event until released and pressed
    btn_start_n = 1'b0;
    reset       = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(20);
    check("held_no_ev", 32'(running), 32'd0);
    btn_start_n = 1'b1;
    wait_clk(10);
    push(1'b1, 1'b0);
    check("held_repress", 32'(running), 32'd1);

    // Pause at 00.05 keeps the partial prescaler period (2 of 10 used)
    do_reset();
    push(1'b1, 1'b0);
    wait_clk(44);
    push(1'b1, 1'b0);
    upd_mark = upd_total;
    wait_clk(50);
    check("pause_digits",  32'(digits), 32'h0005);
    check("pause_running", 32'(running), 32'd0);
    check("pause_noupd",   32'(upd_total - upd_mark), 32'd0);
    push(1'b1, 1'b0);
    wait_clk(6);
    check("resume_early", 32'(digits), 32'h0005);
    wait_clk(1);
    check("resume_tick",  32'(digits), 32'h0006);

    // Lap hold at 00.12, release at live 00.17
    do_reset();
    push(1'b1, 1'b0);
    wait_clk(116);
    push(1'b0, 1'b1);
    check("lap_set_act", 32'(lap_active), 32'd1);
    check("lap_set_dig", 32'(digits), 32'h0012);
    wait_clk(44);
    check("lap_frozen",  32'(digits), 32'h0012);
    push(1'b0, 1'b1);
    check("lap_clr_dig", 32'(digits), 32'h0017);
    check("lap_clr_act", 32'(lap_active), 32'd0);

    // Simultaneous start+lap from PAUSE resumes without clearing; then mid-count reset
    do_reset();
    push(1'b1, 1'b0);
    wait_clk(30);
    push(1'b1, 1'b0);
    wait_clk(10);
    check("both_paused", 32'(running), 32'd0);
    push(1'b1, 1'b1);
    check("both_run",  32'(running), 32'd1);
    check("both_dig",  32'(digits), 32'h0003);
    check("both_lap",  32'(lap_active), 32'd0);
    wait_clk(1);
    check("both_count", 32'(digits), 32'h0004);
    reset = 1'b1;
    wait_clk(1);
    check("mid_rst_dig", 32'(digits), 32'h0);
    check("mid_rst_run", 32'(running), 32'd0);
    check("mid_rst_lap", 32'(lap_active), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_upd", 32'(update), 32'd0);
    reset = 1'b0;
    wait_clk(8);

    // Wrap 59.99 -> 00.00 sets sticky overflow; pause + lap clears it
    do_reset();
    push(1'b1, 1'b0);
    wait_clk(59989);
    check("pre_wrap_dig", 32'(digits), 32'h5999);
    check("pre_wrap_ovf", 32'(overflow), 32'd0);
    wait_clk(10);
    check("wrap_dig", 32'(digits), 32'h0000);
    check("wrap_ovf", 32'(overflow), 32'd1);
    wait_clk(20);
    check("post_wrap_dig", 32'(digits), 32'h0002);
    check("ovf_sticky",    32'(overflow), 32'd1);
    push(1'b1, 1'b0);
    wait_clk(8);
    push(1'b0, 1'b1);
    check("clear_dig", 32'(digits), 32'h0000);
    check("clear_ovf", 32'(overflow), 32'd0);
    check("clear_run", 32'(running), 32'd0);
    wait_clk(30);
    check("clear_idle", 32'(digits), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd_core.md
STOPWATCH_BCD_CORE -- requirements
Module: stopwatch_bcd_core

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, count rate in Hz (hundredths of a second); CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000000, clocks a synchronized button level must stay stable before it is accepted (20 ms at 50 MHz).
REQ-004 Port clk_50, input, 1, the only clock; all logic SHALL be on its rising edge.
REQ-005 Port reset, input, 1, synchronous, active-high reset.
REQ-006 Port btn_start_n, input, 1, raw asynchronous start/stop key, low = pressed.
REQ-007 Port btn_lap_n, input, 1, raw asynchronous lap/clear key, low = pressed.
REQ-008 Port digits, output, 16, four BCD nibbles: [15:12] tens of seconds, [11:8] seconds, [7:4] tenths, [3:0] hundredths; feeds the 7-segment scan driver.
REQ-009 Port running, output, 1, high while the FSM is in RUN.
REQ-010 Port lap_active, output, 1, high while digits shows a frozen lap snapshot.
REQ-011 Port overflow, output, 1, sticky flag, set on wrap 59.99 -> 00.00.
REQ-012 Port update, output, 1, one-cycle strobe asserted in the cycle after digits changes value.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that updates its accepted level only after DEBOUNCE_CYCLES consecutive identical synchronized samples; any mismatch restarts the count.
REQ-014 A press event SHALL be a single-cycle pulse on an accepted-level transition released -> pressed; release SHALL generate no event.
REQ-015 The FSM SHALL have states IDLE, RUN, PAUSE.
REQ-016 Start press: IDLE -> RUN, RUN -> PAUSE, PAUSE -> RUN.
REQ-017 Lap press in RUN SHALL toggle lap hold: when hold sets, the live count is captured into the snapshot in the same cycle; when hold clears, digits follows the live count again.
REQ-018 Lap press in PAUSE SHALL clear: live count, snapshot, prescaler, overflow and hold to zero; next state IDLE.
REQ-019 Lap press in IDLE SHALL be ignored.
REQ-020 Start and lap events in the same cycle: start SHALL be processed, lap SHALL be dropped.
REQ-021 The prescaler SHALL count 0 .. CLK_HZ/TICK_HZ-1 only in RUN, emit a tick at the terminal value and wrap to 0; in PAUSE it SHALL hold its value, so resuming preserves the partial period.
REQ-022 On each tick the hundredths digit SHALL increment; each digit 0-9 wraps 9 -> 0 with carry to the next; the tens-of-seconds digit SHALL wrap 5 -> 0.
REQ-023 A tick at 59.99 SHALL produce 00.00 and set overflow; counting continues; overflow clears only on clear (REQ-018) or reset.
REQ-024 Every digit nibble SHALL only ever hold 0-9, tens-of-seconds 0-5.
REQ-025 digits SHALL be registered: snapshot when hold is set, else live count, one clock after the source changes.
REQ-026 Lap hold SHALL persist through RUN -> PAUSE -> RUN; counting continues underneath.
REQ-027 running and lap_active SHALL be registered decodes of state and hold.

Reset
REQ-028 While reset is high at a rising edge: state IDLE, count, snapshot, prescaler, debounce counters zero; synchronizers and accepted levels = released (1); digits = 16'h0000, running = 0, lap_active = 0, overflow = 0, update = 0.
REQ-029 Reset SHALL take priority over every event and apply mid-count; no press event SHALL be generated for a button already held low when reset deasserts until it is released and pressed again.

Verification (CLK_HZ=100, TICK_HZ=10, DEBOUNCE_CYCLES=4)
REQ-030 Start press, run 100 clocks -> digits = 16'h0010, running = 1, update pulses once per 10 clocks.
REQ-031 Start key bouncing with pulses shorter than 4 clocks, then stable low -> exactly one start event; state RUN.
REQ-032 At 00.05 start press (PAUSE), wait 50 clocks, start press again -> digits unchanged during pause, next increment arrives after the remaining prescaler period only.
REQ-033 Run from 16'h5998 for 20 clocks -> 16'h0000 after the second tick, overflow = 1 and stays 1; later PAUSE + lap -> IDLE, digits 16'h0000, overflow = 0.
REQ-034 In RUN at 00.12 lap press -> lap_active = 1, digits frozen at 16'h0012 for 50 clocks; lap press again -> digits jumps to live 16'h0017.
REQ-035 Start and lap events in the same cycle from PAUSE -> RUN, count not cleared; reset asserted mid-count -> all outputs at REQ-028 values on the next edge.
